// File: rtl/register_bus_master.sv
// Initiator for the TTM4 register bus: source -> LOADBUS + imm -> STOREBUS -> store.
// REGBUS_CARRY_EN enables the carry flag and conditional (JNC-style) stores.
module register_bus_master #(
  parameter int DATA_W        = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_SRC,
  input  logic [1:0]        CMD_DST,
  input  logic [DATA_W-1:0] CMD_IMM,
  input  logic              CMD_COND,
  input  logic [DATA_W-1:0] IN_PORT,
  input  logic [DATA_W-1:0] LOADBUS,
  output logic              nA_OUT,
  output logic              nB_OUT,
  output logic              nA_ST,
  output logic              nB_ST,
  output logic              nOUT_ST,
  output logic              nPC_LD,
  output logic [DATA_W-1:0] STOREBUS,
  output logic              DONE,
  output logic              C_FLAG
);

`ifdef REGBUS_CARRY_EN
  localparam bit CARRY_EN = 1'b1;
`else
  localparam bit CARRY_EN = 1'b0;
`endif

  localparam int CW = 8;
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] STROBE_LAST = CW'(STROBE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_STORE,
    S_HOLD
  } state_t;

  state_t r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx;

  logic [1:0]        r_src, r_dst;
  logic [DATA_W-1:0] r_imm;
  logic              r_skip, r_carry;

  logic              w_accept, w_sample;
  logic [1:0]        w_src;
  logic [DATA_W-1:0] w_operand;
  logic [DATA_W:0]   w_sum;
  logic              w_st_en;
  logic [3:0]        w_st_n;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_accept   = 1'b0;
    w_sample   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (CMD_VALID && CMD_READY) begin
          w_accept   = 1'b1;
          w_state_nx = S_DRIVE;
          w_cnt_nx   = '0;
        end
      end
      S_DRIVE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_sample   = 1'b1;
          w_state_nx = S_STORE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_STORE: begin
        if (r_cnt == STROBE_LAST) begin
          w_state_nx = S_HOLD;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_HOLD: begin
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output enables must be valid in the first DRIVE cycle, before r_src loads.
  assign w_src = w_accept ? CMD_SRC : r_src;

  always_comb begin
    w_operand = '0;
    unique case (r_src)
      2'd0, 2'd1: w_operand = LOADBUS;
      2'd2:       w_operand = IN_PORT;
      default:    w_operand = '0;
    endcase
  end

  assign w_sum   = {1'b0, w_operand} + {1'b0, r_imm};
  assign w_st_en = (w_state_nx == S_STORE) && !r_skip;

  always_comb begin
    w_st_n = 4'b1111;
    if (w_st_en) begin
      unique case (1'b1)
        r_dst == 2'd0: w_st_n[0] = 1'b0;
        r_dst == 2'd1: w_st_n[1] = 1'b0;
        r_dst == 2'd2: w_st_n[2] = 1'b0;
        r_dst == 2'd3: w_st_n[3] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_imm     <= '0;
      r_skip    <= 1'b0;
      r_carry   <= 1'b0;
      CMD_READY <= 1'b0;
      nA_OUT    <= 1'b1;
      nB_OUT    <= 1'b1;
      nA_ST     <= 1'b1;
      nB_ST     <= 1'b1;
      nOUT_ST   <= 1'b1;
      nPC_LD    <= 1'b1;
      STOREBUS  <= '0;
      DONE      <= 1'b0;
      C_FLAG    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_src  <= CMD_SRC;
        r_dst  <= CMD_DST;
        r_imm  <= CMD_IMM;
        r_skip <= CARRY_EN & CMD_COND & C_FLAG;
      end
      if (w_sample) begin
        STOREBUS <= w_sum[DATA_W-1:0];
        r_carry  <= w_sum[DATA_W];
      end
      if (w_state_nx == S_HOLD) begin
        C_FLAG <= CARRY_EN & r_carry;
      end
      CMD_READY <= (w_state_nx == S_IDLE);
      nA_OUT    <= !((w_state_nx == S_DRIVE) && (w_src == 2'd0));
      nB_OUT    <= !((w_state_nx == S_DRIVE) && (w_src == 2'd1));
      nA_ST     <= w_st_n[0];
      nB_ST     <= w_st_n[1];
      nOUT_ST   <= w_st_n[2];
      nPC_LD    <= w_st_n[3];
      DONE      <= (w_state_nx == S_HOLD);
    end
  end

endmodule
